encoder_8to3_stream: RTL and testbench
======================================

// Module: encoder_8to3_stream
// PURPOSE
//  Inverse of the team's one-hot decoder chain: accepts a multi-hot request vector and emits, one beat
//  per set bit, the binary index of each asserted bit, highest bit first. Sits between request/flag
//  sources and consumers that need binary indices. Uses valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH   8                  number of request bits (power of two, >= 2)
//  IDX_W   $clog2(WIDTH) = 3  localparam: index width
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  enable     in   1      permits acceptance of a new vector; a scan in progress is not aborted
//  in_valid   in   1      req is valid
//  in_ready   out  1      block accepts req this cycle
//  req        in   WIDTH  multi-hot request vector
//  out_valid  out  1      idx/last/none are valid
//  out_ready  in   1      consumer accepts current beat
//  idx        out  IDX_W  binary index of current set bit
//  last       out  1      current beat is the final beat for the accepted vector
//  none       out  1      accepted vector was all-zero; idx = 0 on this beat
// BEHAVIOUR
//  - Reset: state IDLE, pending = 0, in_ready = 0, out_valid = 0, idx = 0, last = 0, none = 0.
//  - FSM states: IDLE, SCAN, ZERO.
//  - IDLE: in_ready = enable. On in_valid & in_ready: pending <= req; next = (req == 0) ? ZERO : SCAN.
//  - SCAN: out_valid = 1, in_ready = 0; idx = highest set bit of pending; last = (exactly one bit set).
//    On out_ready: clear bit idx in pending; if last, go to IDLE, else stay in SCAN.
//  - ZERO: out_valid = 1, idx = 0, none = 1, last = 1; on out_ready go to IDLE.
//  - Latency: vector accepted at edge N -> first beat valid after edge N (cycle N+1). One index per
//    cycle while out_ready held high. Vector with k set bits takes k beats (zero vector: 1 beat).
//  - Back-to-back: in_ready is 0 in SCAN/ZERO, so the next vector can be accepted one cycle after the
//    last beat completes; no combinational path from out_ready to in_ready.
//  - Stall: with out_ready = 0, idx/last/none/out_valid stay constant.
//  - enable deasserted during SCAN/ZERO: current vector completes; only new acceptance is blocked.
//  - Asynchronous reset mid-scan: pending discarded, all outputs return to reset values immediately.
//  - idx, last and none are decoded combinationally from the registered pending and state, so they
//    change only on clock edges; out_valid depends on state only.
// CONFIGURATION
//  ENCODER_LSB_FIRST_EN  defined: priority is reversed; idx = lowest set bit of pending, emitted
//                        ascending. Undefined (default): highest set bit first, emitted descending.
//                        Handshake, latency, last/none rules identical in both builds.
// STRUCTURE
//  encoder_pkg: typedef enum logic [1:0] {IDLE, SCAN, ZERO} enc_state_e; ENC_WIDTH_DEF = 8.
//  Sub-module enc_find_first (combinational, params WIDTH/IDX_W, honours ENCODER_LSB_FIRST_EN):
//    vec -> idx of priority bit, one_left flag. Top holds FSM, pending register and handshakes.
// TESTING
//  1 Reset: rst_n low mid-SCAN of 8'b1010_0001 -> out_valid = 0, in_ready = 0 at once; IDLE after release.
//  2 req = 8'b1010_0001, out_ready = 1 -> beats idx 7,5,0; last only on idx 0; 3 consecutive cycles.
//  3 req = 8'h00 -> single beat idx = 0, none = 1, last = 1; in_ready returns next cycle.
//  4 req = 8'hFF, out_ready toggling 1,0 -> idx 7..0 in order, held stable during each stall cycle.
//  5 enable = 0 with in_valid = 1 -> in_ready = 0, no beat; drop enable mid-scan of 8'h11 -> both beats emitted.
//  6 ENCODER_LSB_FIRST_EN defined, req = 8'b1010_0001 -> beats idx 0,5,7; last on idx 7.

Source files
------------

// File: rtl/encoder_8to3_stream_pkg.sv
// Shared types and constants for the multi-hot to binary-index stream encoder.
package encoder_8to3_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    ZERO = 2'd2
  } enc_state_e;

  localparam int unsigned ENC_WIDTH_DEF = 8;

  // FSM encodings used by the state register
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_ZERO = 2'd2;

endpackage

// File: rtl/encoder_8to3_stream_if.sv
// Request-side and beat-side handshake bundle for encoder_8to3_stream.
interface encoder_8to3_stream_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic             enable;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] req;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic             none;

  modport master (
    output enable, in_valid, req, out_ready,
    input  in_ready, out_valid, idx, last, none
  );

  modport slave (
    input  enable, in_valid, req, out_ready,
    output in_ready, out_valid, idx, last, none
  );
endinterface

// File: rtl/encoder_8to3_stream_enc_find_first.sv
// Priority finder: index of the highest set bit (or lowest when ENCODER_LSB_FIRST_EN
// is defined) plus a flag saying that bit is the only one left.
module enc_find_first #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_one_left
);

  // Later loop iterations win, so loop direction sets the priority.
  always_comb begin
    o_idx = '0;
`ifdef ENCODER_LSB_FIRST_EN
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
`else
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
`endif
    o_one_left = (i_vec != '0) && ((i_vec & (i_vec - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/encoder_8to3_stream.sv
// Multi-hot request vector in, one binary index beat per set bit out.
// Optional build macro: ENCODER_LSB_FIRST_EN (lowest set bit first, ascending).
module encoder_8to3_stream
  import encoder_8to3_stream_pkg::*;
#(
  parameter int unsigned WIDTH = ENC_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  encoder_8to3_stream_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] w_pending_nxt;
  logic             r_active;
  logic [IDX_W-1:0] w_ff_idx;
  logic             w_ff_one;
  logic             w_in_ready;
  logic             w_out_valid;
  logic [IDX_W-1:0] w_idx;
  logic             w_last;
  logic             w_none;

  enc_find_first #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_find_first (
    .i_vec      (r_pending),
    .o_idx      (w_ff_idx),
    .o_one_left (w_ff_one)
  );

  // State, pending vector and post-reset qualifier for in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_active  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_active  <= 1'b1;
    end
  end

  // Next-state, pending update and beat decode from registered state only.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_in_ready    = 1'b0;
    w_out_valid   = 1'b0;
    w_idx         = '0;
    w_last        = 1'b0;
    w_none        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = r_active & bus.enable;
        if (bus.in_valid && w_in_ready) begin
          w_pending_nxt = bus.req;
          w_state_nxt   = (bus.req == '0) ? ST_ZERO : ST_SCAN;
        end
      end
      ST_SCAN: begin
        w_out_valid = 1'b1;
        w_idx       = w_ff_idx;
        w_last      = w_ff_one;
        if (bus.out_ready) begin
          w_pending_nxt = r_pending & ~(WIDTH'(1) << w_ff_idx);
          if (w_ff_one) w_state_nxt = ST_IDLE;
        end
      end
      ST_ZERO: begin
        w_out_valid = 1'b1;
        w_none      = 1'b1;
        w_last      = 1'b1;
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_pending_nxt = '0;
      end
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.idx       = w_idx;
  assign bus.last      = w_last;
  assign bus.none      = w_none;

endmodule

// File: tb/tb_encoder_8to3_stream.sv
// Self-checking bench for encoder_8to3_stream against a queue-based reference model.
module tb_encoder_8to3_stream;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  encoder_8to3_stream_if #(.WIDTH(8)) bus ();

  encoder_8to3_stream dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: list of indices to be emitted for a vector, in emission order.
  task automatic model_beats(input logic [7:0] v, output int q[$]);
    q = {};
`ifdef ENCODER_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) if (((v >> i) & 8'd1) == 8'd1) q.push_back(i);
`else
    for (int i = 7; i >= 0; i--) if (((v >> i) & 8'd1) == 8'd1) q.push_back(i);
`endif
    if (q.size() == 0) q.push_back(0);
  endtask

  // mode 0: out_ready held high, 1: toggling 1,0, 2: random. Called at a negedge.
  task automatic run_vector(input logic [7:0] v, input int mode, input bit drop_en);
    int  q[$];
    int  b;
    int  cyc;
    bit  tog;
    bit  en_exp;
    logic [2:0] e_idx;
    logic e_last, e_none;
    model_beats(v, q);
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: in_ready=%b required 1", bus.in_ready);
      return;
    end
    bus.in_valid = 1'b1;
    bus.req      = v;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.req      = 8'($urandom);
    if (drop_en) bus.enable = 1'b0;
    en_exp = bus.enable;
    b   = 0;
    cyc = 0;
    tog = 1'b1;
    while (b < q.size() && cyc < 200) begin
      e_idx  = 3'(q[b]);
      e_last = (b == q.size() - 1);
      e_none = (v == 8'h00);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.idx !== e_idx || bus.last !== e_last ||
          bus.none !== e_none || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL beat v=%h b=%0d: valid=%b idx=%0d last=%b none=%b in_ready=%b required 1 %0d %b %b 0",
                 v, b, bus.out_valid, bus.idx, bus.last, bus.none, bus.in_ready, e_idx, e_last, e_none);
      end
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       begin bus.out_ready = tog; tog = ~tog; end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk);
      if (bus.out_ready) b++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== en_exp) begin
      errors++;
      $display("FAIL after_last v=%h: out_valid=%b in_ready=%b required 0 %b",
               v, bus.out_valid, bus.in_ready, en_exp);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.enable    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.req       = 8'h00;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.idx !== 3'd0 ||
        bus.last !== 1'b0 || bus.none !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b vld=%b idx=%0d last=%b none=%b required all 0",
               bus.in_ready, bus.out_valid, bus.idx, bus.last, bus.none);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: rdy=%b vld=%b required 1 0", bus.in_ready, bus.out_valid);
    end
    // Reset in the middle of a scan of 8'b1010_0001.
    bus.in_valid = 1'b1;
    bus.req      = 8'hA1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL scan_started: out_valid=%b required 1", bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.idx !== 3'd0 ||
        bus.last !== 1'b0 || bus.none !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_scan: rdy=%b vld=%b idx=%0d last=%b none=%b required all 0",
               bus.in_ready, bus.out_valid, bus.idx, bus.last, bus.none);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_release: rdy=%b vld=%b required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    run_vector(8'hA1, 0, 1'b0);
  endtask

  task automatic test_zero();
    run_vector(8'h00, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_vector(8'hFF, 1, 1'b0);
  endtask

  task automatic test_enable();
    bus.enable   = 1'b0;
    bus.in_valid = 1'b1;
    bus.req      = 8'h3C;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL enable_low: rdy=%b vld=%b required 0 0", bus.in_ready, bus.out_valid);
      end
    end
    bus.in_valid = 1'b0;
    bus.enable   = 1'b1;
    @(negedge clk);
    run_vector(8'h11, 0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL enable_dropped_idle: rdy=%b vld=%b required 0 0", bus.in_ready, bus.out_valid);
    end
    bus.enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_vector(8'h81, 0, 1'b0);
    run_vector(8'h00, 0, 1'b0);
    run_vector(8'h42, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       v = 8'h00;
        1:       v = 8'(8'd1 << $urandom_range(0, 7));
        default: v = 8'($urandom);
      endcase
      run_vector(v, int'($urandom_range(0, 2)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_enable();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
